// File: rtl/icache_dm_lines_pkg.sv
// Shared geometry defaults and refill FSM encoding for the line-based instruction cache.
package icache_dm_lines_pkg;

  localparam int DEF_ADDR_W  = 18;
  localparam int DEF_INDEX_W = 7;
  localparam int DEF_OFF_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/icache_line_ram.sv
// Instruction data array: one synchronous fill write port, one asynchronous lookup read port.
module icache_line_ram
  import icache_dm_lines_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int OFF_W   = DEF_OFF_W
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_widx,
  input  logic [OFF_W-1:0]   i_woff,
  input  logic [31:0]        i_wdata,
  input  logic [INDEX_W-1:0] i_ridx,
  input  logic [OFF_W-1:0]   i_roff,
  output logic [31:0]        o_rdata
);

  logic [31:0] r_mem [2**(INDEX_W+OFF_W)];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[{i_widx, i_woff}] <= i_wdata;
  end

  assign o_rdata = r_mem[{i_ridx, i_roff}];

endmodule

// File: rtl/icache_dm_lines.sv
// Direct-mapped instruction cache with multi-word lines, whole-line refill, flush and
// redirect-tolerant refill. Tag/valid arrays and the refill FSM live here.
module icache_dm_lines
  import icache_dm_lines_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int OFF_W   = DEF_OFF_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc,
  input  logic        jump_wrong,
  input  logic        flush,
  output logic        instr_IF_valid,
  output logic [31:0] instr_IF,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W - 2;
  localparam int LINES = 2 ** INDEX_W;
  localparam int WORDS = 2 ** OFF_W;

  state_t             r_state, w_state_next;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag [LINES];
  logic               r_instr_valid;
  logic [31:0]        r_instr;
  logic               r_mem_req;
  logic [31:0]        r_mem_addr;
  logic [OFF_W-1:0]   r_cnt;
  logic               r_kill;
  logic [INDEX_W-1:0] r_fill_index;
  logic [TAG_W-1:0]   r_fill_tag;

  logic [OFF_W-1:0]   w_offset;
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [31:0]        w_rdata;
  logic               w_start, w_take, w_last;
  logic               w_unused;

  assign w_offset = pc[OFF_W+1:2];
  assign w_index  = pc[OFF_W+INDEX_W+1:OFF_W+2];
  assign w_tag    = pc[ADDR_W-1:ADDR_W-TAG_W];
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_unused = ^{pc[31:ADDR_W], pc[1:0]};

  icache_line_ram #(
    .INDEX_W (INDEX_W),
    .OFF_W   (OFF_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (rdy && w_take),
    .i_widx  (r_fill_index),
    .i_woff  (r_cnt),
    .i_wdata (mem_data),
    .i_ridx  (w_index),
    .i_roff  (w_offset),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else if (rdy) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_take       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_hit) begin
          w_start      = 1'b1;
          w_state_next = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (mem_valid) begin
          w_take = 1'b1;
          if (r_cnt == OFF_W'(WORDS - 1)) begin
            w_last       = 1'b1;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Later assignments win: a completing fill re-validates only when no flush hit it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid       <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_cnt         <= '0;
      r_kill        <= 1'b0;
      r_fill_index  <= '0;
      r_fill_tag    <= '0;
    end else if (rdy) begin
      r_instr_valid <= 1'b0;
      if (r_state == ST_IDLE && w_hit && !jump_wrong && !flush) begin
        r_instr_valid <= 1'b1;
        r_instr       <= w_rdata;
      end
      if (flush) begin
        r_valid <= '0;
        if (r_state == ST_REFILL) r_kill <= 1'b1;
      end
      if (w_start) begin
        r_valid[w_index] <= 1'b0;
        r_fill_index     <= w_index;
        r_fill_tag       <= w_tag;
        r_cnt            <= '0;
        r_mem_req        <= 1'b1;
        r_mem_addr       <= 32'({pc[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}});
        r_kill           <= 1'b0;
      end
      if (w_take) begin
        r_cnt      <= r_cnt + OFF_W'(1);
        r_mem_addr <= r_mem_addr + 32'd4;
      end
      if (w_last) begin
        r_mem_req             <= 1'b0;
        r_valid[r_fill_index] <= !r_kill && !flush;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && w_last) r_tag[r_fill_index] <= r_fill_tag;
  end

  assign instr_IF_valid = r_instr_valid;
  assign instr_IF       = r_instr;
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;

endmodule

// File: tb/tb_icache_dm_lines.sv
// Self-checking bench for icache_dm_lines: memory model with address scoreboard, table of
// lookups with an expected-output queue, and hand sequences for refill corner cases.
module tb_icache_dm_lines;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] pc;
  logic        jump_wrong;
  logic        flush;
  logic        instr_IF_valid;
  logic [31:0] instr_IF;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        jw;
    logic        fl;
    logic        expValid;
    logic [31:0] expInstr;
  } vec_t;

  exp_t        expQ[$];
  logic [31:0] expAddr[$];
  int          waitCnt = 0;

  icache_dm_lines dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .pc             (pc),
    .jump_wrong     (jump_wrong),
    .flush          (flush),
    .instr_IF_valid (instr_IF_valid),
    .instr_IF       (instr_IF),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_valid      (mem_valid),
    .mem_data       (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory answers each request three cycles after seeing it, and checks request order.
  always @(negedge clk) begin
    if (!rst) begin
      mem_valid = 1'b0;
      waitCnt   = 0;
    end else if (mem_valid) begin
      mem_valid = 1'b0;
      waitCnt   = 0;
    end else if (mem_req) begin
      waitCnt++;
      if (waitCnt == 3) begin
        mem_valid = 1'b1;
        mem_data  = memWord(mem_addr);
        waitCnt   = 0;
        if (expAddr.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected mem_req: got addr 0x%08h, expected no request", mem_addr);
        end else begin
          check("mem_addr order", mem_addr, expAddr.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] p, input logic jw, input logic fl);
    pc         = p;
    jump_wrong = jw;
    flush      = fl;
    rdy        = 1'b1;
    @(negedge clk);
    jump_wrong = 1'b0;
    flush      = 1'b0;
    rdy        = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got output with empty scoreboard, expected a queued entry", name);
      return;
    end
    e = expQ.pop_front();
    check({name, " valid"}, 32'(instr_IF_valid), 32'(e.valid));
    if (e.valid) check({name, " instr"}, instr_IF, e.instr);
  endtask

  task automatic lookup(input string name, input logic [31:0] p, input logic jw,
                        input logic fl, input logic ev, input logic [31:0] ei);
    exp_t e;
    e.valid = ev;
    e.instr = ei;
    expQ.push_back(e);
    applyStimulus(p, jw, fl);
    checkOutput(name);
  endtask

  // inject: 0 none, 1 jump_wrong, 2 flush, raised while the second word is outstanding.
  task automatic fillLine(input logic [31:0] p, input int inject);
    logic [31:0] base;
    int cyc;
    int busyValid;
    bit injected;
    base = {p[31:4], 4'b0} & 32'h0003_FFFF;
    for (int w = 0; w < 4; w++) expAddr.push_back(base + 32'(4 * w));
    applyStimulus(p, 1'b0, 1'b0);
    check("miss req", 32'(mem_req), 32'd1);
    check("miss addr", mem_addr, base);
    check("miss valid", 32'(instr_IF_valid), 32'd0);
    rdy = 1'b1;
    cyc = 0;
    busyValid = 0;
    injected = 1'b0;
    while (mem_req === 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      jump_wrong = 1'b0;
      flush      = 1'b0;
      if (instr_IF_valid) busyValid++;
      if (!injected && inject != 0 && mem_req && mem_addr == base + 32'd4) begin
        injected = 1'b1;
        pc = 32'h0000_0200;
        if (inject == 1) jump_wrong = 1'b1;
        else flush = 1'b1;
      end
    end
    rdy = 1'b0;
    if (cyc >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL refill timeout: got mem_req still 1 after %0d cycles, expected 0", cyc);
    end
    check("refill quiet", 32'(busyValid), 32'd0);
    check("words requested", 32'(expAddr.size()), 32'd0);
    applyStimulus(p, 1'b0, 1'b0);
    check("done bubble", 32'(instr_IF_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{32'h14, 1'b0, 1'b0, 1'b1, memWord(32'h14)};
    tbl[1] = '{32'h18, 1'b0, 1'b0, 1'b1, memWord(32'h18)};
    tbl[2] = '{32'h1C, 1'b0, 1'b0, 1'b1, memWord(32'h1C)};
    tbl[3] = '{32'h14, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{32'h18, 1'b0, 1'b0, 1'b1, memWord(32'h18)};

    rst = 1'b1; rdy = 1'b0; pc = '0; jump_wrong = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_data = '0;
    #1 rst = 1'b0;
    #1;
    check("reset valid", 32'(instr_IF_valid), 32'd0);
    check("reset instr", instr_IF, 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, then sequential hits from the table.
    fillLine(32'h10, 0);
    lookup("cold hit 0x10", 32'h10, 1'b0, 1'b0, 1'b1, memWord(32'h10));
    for (int i = 0; i < 5; i++) begin
      lookup($sformatf("table %0d", i), tbl[i].pc, tbl[i].jw, tbl[i].fl,
             tbl[i].expValid, tbl[i].expInstr);
      check("table mem_req", 32'(mem_req), 32'd0);
    end

    // rdy low freezes outputs even while pc moves.
    pc = 32'h10;
    repeat (3) @(negedge clk);
    check("hold valid", 32'(instr_IF_valid), 32'd1);
    check("hold instr", instr_IF, memWord(32'h18));

    // Conflict on index 0 between tags 0 and 1.
    fillLine(32'h0, 0);
    lookup("hit 0x0", 32'h0, 1'b0, 1'b0, 1'b1, memWord(32'h0));
    fillLine(32'h800, 0);
    lookup("hit 0x800", 32'h800, 1'b0, 1'b0, 1'b1, memWord(32'h800));
    fillLine(32'h0, 0);
    lookup("rehit 0x0", 32'h0, 1'b0, 1'b0, 1'b1, memWord(32'h0));

    // Redirect mid-refill: the line still completes and is usable.
    fillLine(32'h40, 1);
    lookup("jw line 0x44", 32'h44, 1'b0, 1'b0, 1'b1, memWord(32'h44));
    check("jw no traffic", 32'(mem_req), 32'd0);

    // Flush mid-refill: the line lands invalid and older lines are gone too.
    fillLine(32'h80, 2);
    fillLine(32'h80, 0);
    lookup("refilled 0x80", 32'h80, 1'b0, 1'b0, 1'b1, memWord(32'h80));
    fillLine(32'h10, 0);
    lookup("refilled 0x10", 32'h10, 1'b0, 1'b0, 1'b1, memWord(32'h10));
    lookup("flush with hit", 32'h14, 1'b0, 1'b1, 1'b0, 32'h0);
    fillLine(32'h14, 0);
    lookup("after flush 0x14", 32'h14, 1'b0, 1'b0, 1'b1, memWord(32'h14));

    // Asynchronous reset in the middle of a refill.
    for (int w = 0; w < 4; w++) expAddr.push_back(32'h20 + 32'(4 * w));
    applyStimulus(32'h20, 1'b0, 1'b0);
    rdy = 1'b1;
    repeat (5) @(negedge clk);
    check("refill busy", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async mem_req", 32'(mem_req), 32'd0);
    check("async valid", 32'(instr_IF_valid), 32'd0);
    check("async mem_addr", mem_addr, 32'd0);
    expAddr.delete();
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    fillLine(32'h10, 0);
    lookup("post reset 0x10", 32'h10, 1'b0, 1'b0, 1'b1, memWord(32'h10));

    check("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
